// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   - fetch_state_e : sequencer states (request, wait for data, hold for ID)
//   - redir_src_e   : which redirect source won arbitration this cycle
//   - DEF_RESET_PC / DEF_EXC_VEC : default reset PC and exception vector
//   - is_misaligned : true when an instruction address is not word aligned
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'hbfc0_0380;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_EXC    = 3'd1,
    SRC_ERET   = 3'd2,
    SRC_JUMP   = 3'd3,
    SRC_BRANCH = 3'd4
  } redir_src_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/redirect_sel.sv
// redirect_sel: combinational priority selector for PC redirects.
// Priority exp_handle > eret > jump > branch.
// Ports:
//   exp_handle, eret, jump, branch : redirect requests
//   epc, jump_addr, branch_addr    : redirect targets
//   redir_valid      : some redirect requested this cycle
//   redir_target     : target of the winning request
//   redir_misaligned : winning target is not word aligned
module redirect_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic        exp_handle,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output logic        redir_misaligned
);

  redir_src_e src;

  // Pick the highest-priority active redirect source.
  always_comb begin
    src = SRC_NONE;
    if (exp_handle) begin
      src = SRC_EXC;
    end else if (eret) begin
      src = SRC_ERET;
    end else if (jump) begin
      src = SRC_JUMP;
    end else if (branch) begin
      src = SRC_BRANCH;
    end else begin
      src = SRC_NONE;
    end
  end

  // Map the winning source to its target address.
  always_comb begin
    redir_target = 32'h0000_0000;
    case (src)
      SRC_EXC:    redir_target = EXC_VEC;
      SRC_ERET:   redir_target = epc;
      SRC_JUMP:   redir_target = jump_addr;
      SRC_BRANCH: redir_target = branch_addr;
      default:    redir_target = 32'h0000_0000;
    endcase
  end

  assign redir_valid      = (src != SRC_NONE);
  assign redir_misaligned = is_misaligned(redir_target);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer. Owns the PC, drives an SRAM-like
// instruction bus with at most one outstanding transaction, resolves
// redirects against in-flight fetches and hands one registered instruction
// per handshake to ID.
// Ports:
//   clk, rst (async, active-low)
//   exp_handle / eret+epc / jump+jump_addr / branch+branch_addr : redirects
//   id_stall     : ID cannot accept the held instruction
//   inst_req, inst_addr, inst_addr_ok, inst_data_ok, inst_rdata : bus
//   if_valid, if_pc, if_inst, if_pc_exp : instruction towards ID
//   busy         : a bus transaction is in REQ or WAIT
// Optional macro PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exp_handle,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  input  logic        id_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_pc_exp,
  output logic        busy
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  fetch_state_e state;
  logic [31:0]  pc_q;
  logic         redir_pend;
  logic [31:0]  pend_target;
  logic         redir_valid;
  logic [31:0]  redir_target;
  logic         redir_misaligned;

  redirect_sel #(.EXC_VEC(EXC_VEC)) u_redirect_sel (
    .exp_handle       (exp_handle),
    .eret             (eret),
    .epc              (epc),
    .jump             (jump),
    .jump_addr        (jump_addr),
    .branch           (branch),
    .branch_addr      (branch_addr),
    .redir_valid      (redir_valid),
    .redir_target     (redir_target),
    .redir_misaligned (redir_misaligned)
  );

  assign inst_addr = pc_q;
  assign busy      = (state != S_HOLD);

  // Fetch sequencer: PC, bus request and the registered ID-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc_q        <= RESET_PC;
      redir_pend  <= 1'b0;
      pend_target <= 32'h0000_0000;
      inst_req    <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0000_0000;
      if_inst     <= 32'h0000_0000;
      if_pc_exp   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!inst_req) begin
            // Nothing on the bus yet, so a redirect can retarget pc_q directly.
            if (redir_valid) begin
              pc_q     <= redir_target;
              inst_req <= !redir_misaligned;
            end else if (is_misaligned(pc_q)) begin
              // Misaligned PC: no bus access, deliver an AdEL marker instead.
              state     <= S_HOLD;
              if_valid  <= 1'b1;
              if_pc     <= pc_q;
              if_inst   <= 32'h0000_0000;
              if_pc_exp <= 1'b1;
            end else begin
              inst_req <= 1'b1;
            end
          end else begin
            // Address must stay stable until accepted; remember the redirect.
            if (redir_valid) begin
              redir_pend  <= 1'b1;
              pend_target <= redir_target;
            end
            if (inst_addr_ok) begin
              inst_req <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            // A same-cycle redirect is newer than any latched one.
            if (redir_valid) begin
              pc_q       <= redir_target;
              inst_req   <= !redir_misaligned;
              redir_pend <= 1'b0;
              state      <= S_REQ;
            end else if (redir_pend) begin
              pc_q       <= pend_target;
              inst_req   <= !is_misaligned(pend_target);
              redir_pend <= 1'b0;
              state      <= S_REQ;
            end else begin
              if_valid  <= 1'b1;
              if_pc     <= pc_q;
              if_inst   <= inst_rdata;
              if_pc_exp <= 1'b0;
              state     <= S_HOLD;
            end
          end else if (redir_valid) begin
            redir_pend  <= 1'b1;
            pend_target <= redir_target;
          end
        end
        S_HOLD: begin
          if (redir_valid) begin
            if_valid <= 1'b0;
            pc_q     <= redir_target;
            inst_req <= !redir_misaligned;
            state    <= S_REQ;
          end else if (!id_stall) begin
            if_valid <= 1'b0;
            pc_q     <= pc_q + 32'd4;
            inst_req <= !is_misaligned(pc_q + 32'd4);
            state    <= S_REQ;
          end
        end
        default: begin
          state    <= S_REQ;
          inst_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Count instructions taken by ID and cycles where ID was starved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= 32'h0000_0000;
      bubble_cnt <= 32'h0000_0000;
    end else begin
      if (if_valid && !id_stall && !redir_valid) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (!if_valid && !id_stall) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl. Expected
// deliveries are queued when the bench returns read data and are compared
// when the sequencer presents them to ID.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exp_handle = 1'b0, eret = 1'b0, jump = 1'b0, branch = 1'b0;
  logic [31:0] epc = 32'h0, jump_addr = 32'h0, branch_addr = 32'h0;
  logic        id_stall = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        if_valid, if_pc_exp, busy;
  logic [31:0] if_pc, if_inst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .exp_handle(exp_handle), .eret(eret), .epc(epc),
    .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_addr(branch_addr),
    .id_stall(id_stall),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_pc_exp(if_pc_exp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a bus request and check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    for (int i = 0; i < 40 && inst_req !== 1'b1; i++) tick();
    chk({tag, "_req"}, {31'd0, inst_req}, 32'd1);
    chk({tag, "_addr"}, inst_addr, exp_addr);
  endtask

  // Hold addr_ok low for lat cycles (address must stay put), then accept.
  task automatic addr_phase(input string tag, input int lat, input logic [31:0] a);
    for (int i = 0; i < lat; i++) begin
      inst_addr_ok = 1'b0;
      tick();
      chk({tag, "_stable"}, inst_addr, a);
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, inst_req}, 32'd0);
  endtask

  // Return read data after lat idle cycles; optionally queue the delivery.
  task automatic data_phase(input int lat, input logic [31:0] rd, input bit push,
                            input logic [31:0] pc);
    exp_t e;
    for (int i = 0; i < lat; i++) tick();
    inst_data_ok = 1'b1;
    inst_rdata   = rd;
    if (push) begin
      e.pc = pc; e.inst = rd; e.exc = 1'b0;
      sb.push_back(e);
    end
    tick();
    inst_data_ok = 1'b0;
  endtask

  // Compare the instruction presented to ID with the oldest queued entry.
  task automatic check_out(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=delivery expected=empty_scoreboard", tag);
    end else begin
      last = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
      chk({tag, "_pc"}, if_pc, last.pc);
      chk({tag, "_inst"}, if_inst, last.inst);
      chk({tag, "_exc"}, {31'd0, if_pc_exp}, {31'd0, last.exc});
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input int alat,
                       input int dlat, input logic [31:0] rd);
    wait_req(tag, a);
    addr_phase(tag, alat, a);
    data_phase(dlat, rd, 1'b1, a);
    check_out(tag);
  endtask

  initial begin
    exp_t e;
    // Reset state
    tick();
    tick();
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_exc", {31'd0, if_pc_exp}, 32'd0);
    chk("rst_addr", inst_addr, 32'hbfc0_0000);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;

    // Back-to-back fetches, zero-wait memory
    tick();
    wait_req("f0", 32'hbfc0_0000);
    addr_phase("f0", 0, 32'hbfc0_0000);
    chk("f0_wait_valid", {31'd0, if_valid}, 32'd0);
    chk("f0_wait_busy", {31'd0, busy}, 32'd1);
    data_phase(0, 32'h1111_0000, 1'b1, 32'hbfc0_0000);
    check_out("f0");
    tick();
    fetch("f1", 32'hbfc0_0004, 0, 0, 32'h1111_0004);

    // ID stall for 5 cycles; data_ok in HOLD must be ignored
    id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_data_ok = (i == 2);
      inst_rdata   = 32'hdead_beef;
      tick();
      inst_data_ok = 1'b0;
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, last.pc);
      chk("stall_inst", if_inst, last.inst);
      chk("stall_req", {31'd0, inst_req}, 32'd0);
    end
    id_stall = 1'b0;
    tick();
    wait_req("after_stall", 32'hbfc0_0008);

    // Branch during WAIT; late response must be discarded
    addr_phase("br", 0, 32'hbfc0_0008);
    branch = 1'b1; branch_addr = 32'h8000_1000;
    tick();
    branch = 1'b0;
    tick();
    tick();
    chk("br_no_valid", {31'd0, if_valid}, 32'd0);
    data_phase(0, 32'h2222_2222, 1'b0, 32'h0);
    chk("br_drop_valid", {31'd0, if_valid}, 32'd0);
    fetch("br_tgt", 32'h8000_1000, 2, 1, 32'h3333_1000);

    // Exception and jump together in HOLD: exception wins, held inst dropped
    id_stall = 1'b1; exp_handle = 1'b1; jump = 1'b1; jump_addr = 32'h1234_5678;
    tick();
    exp_handle = 1'b0; jump = 1'b0; id_stall = 1'b0;
    chk("exc_drop_valid", {31'd0, if_valid}, 32'd0);
    fetch("exc", 32'hbfc0_0380, 0, 0, 32'h4444_0380);

    // Misaligned jump (beats a simultaneous branch): AdEL marker, no request
    jump = 1'b1; jump_addr = 32'h8000_0002;
    branch = 1'b1; branch_addr = 32'h8000_7000;
    tick();
    jump = 1'b0; branch = 1'b0;
    chk("mis_no_req", {31'd0, inst_req}, 32'd0);
    e.pc = 32'h8000_0002; e.inst = 32'h0; e.exc = 1'b1;
    sb.push_back(e);
    id_stall = 1'b1;
    tick();
    check_out("mis");
    chk("mis_no_req2", {31'd0, inst_req}, 32'd0);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    exp_handle = 1'b1;
    tick();
    exp_handle = 1'b0; id_stall = 1'b0;

    // addr_ok held off 4 cycles with eret mid-wait
    wait_req("eret", 32'hbfc0_0380);
    epc = 32'h8000_4000;
    for (int i = 0; i < 4; i++) begin
      eret = (i == 1);
      tick();
      chk("eret_stable", inst_addr, 32'hbfc0_0380);
      chk("eret_req_held", {31'd0, inst_req}, 32'd1);
    end
    eret = 1'b0;
    addr_phase("eret_acc", 0, 32'hbfc0_0380);
    data_phase(1, 32'h5555_5555, 1'b0, 32'h0);
    chk("eret_drop_valid", {31'd0, if_valid}, 32'd0);
    fetch("epc", 32'h8000_4000, 0, 0, 32'h6666_4000);

    // Redirect together with addr_ok; eret beats branch
    tick();
    wait_req("sameacc", 32'h8000_4004);
    epc = 32'h8000_5000; eret = 1'b1;
    branch = 1'b1; branch_addr = 32'h8000_6000;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; eret = 1'b0; branch = 1'b0;
    data_phase(0, 32'h7777_7777, 1'b0, 32'h0);
    chk("sameacc_drop", {31'd0, if_valid}, 32'd0);
    fetch("eret_tgt", 32'h8000_5000, 0, 0, 32'h8888_5000);

    // PC wrap at 2^32
    jump = 1'b1; jump_addr = 32'hffff_fffc;
    tick();
    jump = 1'b0;
    fetch("top", 32'hffff_fffc, 0, 0, 32'h9999_fffc);
    tick();
    wait_req("wrap", 32'h0000_0000);

    // Redirect in the same cycle as data_ok
    addr_phase("samedata", 0, 32'h0000_0000);
    branch = 1'b1; branch_addr = 32'h8000_8000;
    data_phase(0, 32'haaaa_aaaa, 1'b0, 32'h0);
    branch = 1'b0;
    chk("samedata_drop", {31'd0, if_valid}, 32'd0);
    fetch("samedata_tgt", 32'h8000_8000, 0, 0, 32'hbbbb_8000);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
